// File: rtl/ahb_pkg.sv
// Shared AHB-lite codes for the response mux slice:
// transfer types, responses, data-phase selects, default-slave states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int DSEL_W   = 4;
  localparam int DSEL_S0  = 0;
  localparam int DSEL_S1  = 1;
  localparam int DSEL_S2  = 2;
  localparam int DSEL_DEF = 3;

  localparam logic [DSEL_W-1:0] DSEL_S0_OH  = 4'b0001;
  localparam logic [DSEL_W-1:0] DSEL_S1_OH  = 4'b0010;
  localparam logic [DSEL_W-1:0] DSEL_S2_OH  = 4'b0100;
  localparam logic [DSEL_W-1:0] DSEL_DEF_OH = 4'b1000;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } def_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR for active
// transfers that no decoder select claims.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       hready,
  input  logic       hsel_any,
  input  logic [1:0] htrans,
  output logic       def_ready,
  output logic       def_resp
);

  def_state_e state_q;
  def_state_e state_d;
  logic       start;

  // hready here is the muxed bus ready, so a start
  // always coincides with dsel loading DEF.
  assign start = hready && !hsel_any && htrans[1];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    def_ready = 1'b1;
    def_resp  = HRESP_OKAY;
    unique case (state_q)
      DS_IDLE: begin
        if (start) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        def_ready = 1'b0;
        def_resp  = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        def_resp = HRESP_ERROR;
        state_d  = start ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-lite data-phase response mux: registers decoder
// selects at acceptance and steers the slave response back.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = '0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel_0,
  input  logic                  hsel_1,
  input  logic                  hsel_2,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hrdata_0,
  input  logic [DATA_WIDTH-1:0] hrdata_1,
  input  logic [DATA_WIDTH-1:0] hrdata_2,
  input  logic                  hreadyout_0,
  input  logic                  hreadyout_1,
  input  logic                  hreadyout_2,
  input  logic                  hresp_0,
  input  logic                  hresp_1,
  input  logic                  hresp_2,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp
);

  logic [DSEL_W-1:0] dsel_q;
  logic [DSEL_W-1:0] dsel_d;
  logic              hsel_any;
  logic              def_ready;
  logic              def_resp;

  assign hsel_any = hsel_0 | hsel_1 | hsel_2;

  // Fixed priority so a multi-hot select still
  // yields a one-hot dsel.
  always_comb begin
    dsel_d = DSEL_DEF_OH;
    if (hsel_0)      dsel_d = DSEL_S0_OH;
    else if (hsel_1) dsel_d = DSEL_S1_OH;
    else if (hsel_2) dsel_d = DSEL_S2_OH;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)    dsel_q <= DSEL_DEF_OH;
    else if (hready) dsel_q <= dsel_d;
  end

  ahb_default_slave u_def (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hready    (hready),
    .hsel_any  (hsel_any),
    .htrans    (htrans),
    .def_ready (def_ready),
    .def_resp  (def_resp)
  );

  always_comb begin
    hrdata = DEFAULT_RDATA;
    hready = def_ready;
    hresp  = def_resp;
    unique case (1'b1)
      dsel_q[DSEL_S0]: begin
        hrdata = hrdata_0;
        hready = hreadyout_0;
        hresp  = hresp_0;
      end
      dsel_q[DSEL_S1]: begin
        hrdata = hrdata_1;
        hready = hreadyout_1;
        hresp  = hresp_1;
      end
      dsel_q[DSEL_S2]: begin
        hrdata = hrdata_2;
        hready = hreadyout_2;
        hresp  = hresp_2;
      end
      dsel_q[DSEL_DEF]: begin
        hrdata = DEFAULT_RDATA;
        hready = def_ready;
        hresp  = def_resp;
      end
      default: begin
        hrdata = DEFAULT_RDATA;
        hready = def_ready;
        hresp  = def_resp;
      end
    endcase
  end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- Data-phase response multiplexer for the AHB-lite interconnect, directly downstream of the address decoder.
- Registers the decoder's one-hot slave selects (hsel_0..2) at each address-phase acceptance.
- Steers the selected slave's hrdata/hreadyout/hresp back to the master during the following data phase.
- Contains a built-in default slave that returns a two-cycle ERROR response for active transfers to the unmapped region (haddr[15:14]=2'b11, no hsel asserted).

Parameters:
- DATA_WIDTH, 32, width of read-data buses.
- DEFAULT_RDATA, 32'h0000_0000, hrdata value driven while the default slave owns the data phase.

Ports:
- hclk  input  1  bus clock, all state on rising edge.
- hresetn  input  1  asynchronous active-low reset.
- hsel_0  input  1  decoder select, slave 0 (address phase).
- hsel_1  input  1  decoder select, slave 1 (address phase).
- hsel_2  input  1  decoder select, slave 2 (address phase).
- htrans  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- hrdata_0/1/2  input  DATA_WIDTH  slave read data.
- hreadyout_0/1/2  input  1  slave ready.
- hresp_0/1/2  input  1  slave response (0 OKAY, 1 ERROR).
- hrdata  output  DATA_WIDTH  muxed read data to master.
- hready  output  1  muxed ready to master and to all slaves.
- hresp  output  1  muxed response to master.

Behaviour:
- Data-phase select register dsel, 4-bit one-hot {DEF,S2,S1,S0}.
  - Loaded on rising hclk only when hready=1.
  - Load value: S0 if hsel_0, else S1 if hsel_1, else S2 if hsel_2, else DEF. Fixed priority 0>1>2 covers an illegal multi-hot select.
  - Holds its value while hready=0.
- Output mux (combinational from dsel and default-slave state):
  - S0/S1/S2: hrdata/hready/hresp = the corresponding slave's hrdata_n/hreadyout_n/hresp_n.
  - DEF: hrdata=DEFAULT_RDATA, with hready/hresp from the default-slave FSM.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: hready=1, hresp=0. On a clock with hready=1, no hsel asserted and htrans[1]=1 (NONSEQ/SEQ), go to ERR1. Otherwise stay. An IDLE/BUSY htrans to the unmapped region gives a zero-wait OKAY.
  - ERR1: hready=0, hresp=1; unconditionally go to ERR2.
  - ERR2: hready=1, hresp=1. This is an acceptance cycle. If the new address phase is again unmapped NONSEQ/SEQ, go to ERR1; otherwise go to IDLE.
  - FSM outputs reach the master only when dsel=DEF. The FSM advances only when it was triggered from DEF selection, so it never interacts with real-slave data phases.
- Latency:
  - A mapped access's response appears in the cycle after address acceptance and follows hreadyout_n through any wait states.
  - An unmapped active access costs exactly 2 data-phase cycles.
- Reset (asynchronous assert, synchronous deassert via hclk):
  - dsel=DEF, FSM=IDLE.
  - Outputs: hready=1, hresp=0, hrdata=DEFAULT_RDATA.
  - Reset asserted mid-wait-state or mid-ERR1 abandons the transfer immediately; no pending response is replayed after reset.
- Slave wait state: while hreadyout_n=0 of the selected slave, hready=0 and dsel and the FSM are frozen. hsel/htrans changes during the stall are ignored.
- Back-to-back transfers to different slaves switch dsel on the accepting edge with no bubble.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ codes.
  - HRESP_OKAY/HRESP_ERROR.
  - dsel one-hot index constants.
  - Default-slave state encoding.
- One natural sub-module, ahb_default_slave: the FSM plus its hready/hresp generation, instantiated once inside ahb_resp_mux.

Test Plan:
- Reset: hresetn=0 for 3 cycles -> hready=1, hresp=0, hrdata=0. Release with htrans=IDLE -> outputs unchanged.
- Mapped read: hsel_1=1, htrans=NONSEQ, hready=1. Next cycle slave 1 drives hrdata_1=32'hDEAD_BEEF, hreadyout_1=1 -> hrdata=32'hDEAD_BEEF, hresp=0, one-cycle data phase.
- Wait states: hsel_0 access with hreadyout_0 low for 2 cycles, plus hsel_2 presented during the stall -> hready=0 for 2 cycles, dsel stays S0, hsel_2 ignored. Access completes when hreadyout_0=1.
- Unmapped error: no hsel, htrans=NONSEQ -> data phase hready=0/hresp=1, then hready=1/hresp=1, hrdata=0. Repeating with htrans=IDLE -> single OKAY cycle.
- Back-to-back: unmapped NONSEQ, then an hsel_2 NONSEQ accepted in ERR2 -> two-cycle ERROR, then slave 2 response with no idle cycle in between.
- Reset mid-ERR1: assert hresetn=0 during ERR1 -> hready=1, hresp=0 immediately (asynchronously). After release, FSM is IDLE.
